sipo_deser: RTL and testbench

Serial-to-parallel deserializer that sits directly downstream of the PISO shift register and consumes its serial output `q`. It collects WIDTH qualified bits into a word, using optional frame alignment via `sync`. The completed word is presented on a single-entry holding register with a valid/ready handshake. Overrun is detected and flagged when a new word completes while the previous one is still unaccepted.

---
 rtl/sipo_pkg.sv | 16 +
 rtl/sipo_shreg.sv | 32 +++
 rtl/sipo_deser.sv | 126 ++++++++++++
 tb/tb_sipo_deser.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
package sipo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;

   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit shift register with enable; MSB_FIRST picks the shift direction.
// LOOKAHEAD=1 exposes the value after this cycle's shift, 0 exposes the stored value.
module sipo_shreg
   import sipo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit LOOKAHEAD = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] word
);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] nxt;

   always_comb begin
      if (MSB_FIRST) nxt = {sr[WIDTH-2:0], din};
      else           nxt = {din, sr[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  sr <= '0;
      else if (en) sr <= nxt;
   end

   assign word = LOOKAHEAD ? nxt : sr;

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with sync alignment; dout_valid rises 1 clk after the last frame bit.
// Single-entry valid/ready holding register; a word completing while held and not accepted is dropped and sets sticky overrun. Optional parity: PARITY_EN.
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   input  logic             clr_ovr,
   output logic             parity_err
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef PARITY_EN
   localparam bit PAR_BUILD = 1'b1;
`else
   localparam bit PAR_BUILD = 1'b0;
`endif

   state_t           state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] word;
   logic             shift_en;
   logic             last_bit;
   logic             word_done;
   logic             perr_nxt;
   logic             drop;

   always_comb begin
      last_bit = sin_valid && !sync && (state == SHIFT) && (bit_cnt == LAST);
      // The parity bit is not shifted, so the register still holds the data word in PAR.
      shift_en = sin_valid && (sync || (state != PAR));
`ifdef PARITY_EN
      word_done = sin_valid && !sync && (state == PAR);
      perr_nxt  = ^{word, sin};
`else
      word_done = last_bit;
      perr_nxt  = 1'b0;
`endif
      drop = word_done && dout_valid && !dout_ready;
   end

   sipo_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .LOOKAHEAD (!PAR_BUILD)
   ) u_shreg (
      .clk   (clk),
      .reset (reset),
      .en    (shift_en),
      .din   (sin),
      .word  (word)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else if (sin_valid) begin
         if (sync) begin
            state   <= SHIFT;
            bit_cnt <= CW'(1);
         end else begin
            case (state)
               IDLE: begin
                  state   <= SHIFT;
                  bit_cnt <= CW'(1);
               end
               SHIFT: begin
                  if (last_bit) begin
                     bit_cnt <= '0;
`ifdef PARITY_EN
                     state   <= PAR;
`else
                     state   <= IDLE;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
`ifdef PARITY_EN
               PAR: begin
                  state   <= IDLE;
                  bit_cnt <= '0;
               end
`endif
               default: begin
                  state   <= IDLE;
                  bit_cnt <= '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         // A completion on the accept edge refills the register without a bubble.
         if (word_done && !drop) begin
            dout       <= word;
            dout_valid <= 1'b1;
            parity_err <= perr_nxt;
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
         if (drop)         overrun <= 1'b1;
         else if (clr_ovr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sipo_deser.sv
// Randomized and directed bench for sipo_deser: two instances (MSB_FIRST=1/0) share one input stream.
module tb_sipo_deser;

   localparam int W = 4;
`ifdef PARITY_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif

   logic clk = 1'b0;
   logic reset, sin, sin_valid, sync, dout_ready, clr_ovr;
   logic [W-1:0] dout_m, dout_l;
   logic v_m, v_l, o_m, o_l, p_m, p_l;

   int n_checks = 0;
   int n_pass   = 0;

   bit           bits[$];
   logic [W-1:0] m_dout[2];
   bit           m_v[2];
   bit           m_o[2];
   bit           m_p[2];

   always #5 clk = ~clk;

   sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
      .dout(dout_m), .dout_valid(v_m), .dout_ready(dout_ready),
      .overrun(o_m), .clr_ovr(clr_ovr), .parity_err(p_m)
   );

   sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
      .dout(dout_l), .dout_valid(v_l), .dout_ready(dout_ready),
      .overrun(o_l), .clr_ovr(clr_ovr), .parity_err(p_l)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   task automatic model_reset();
      bits.delete();
      for (int k = 0; k < 2; k++) begin
         m_dout[k] = '0; m_v[k] = 0; m_o[k] = 0; m_p[k] = 0;
      end
   endtask

   // Frame model: collect qualified bits in a list; a full list is a word.
   task automatic model_edge();
      bit           done;
      bit           pe;
      logic [W-1:0] w[2];
      done = 0; pe = 0; w[0] = '0; w[1] = '0;
      if (sin_valid) begin
         if (sync) bits.delete();
         bits.push_back(sin);
         if (bits.size() == FRAME) begin
            done = 1;
            for (int i = 0; i < W; i++) begin
               w[0][W-1-i] = bits[i];
               w[1][i]     = bits[i];
            end
`ifdef PARITY_EN
            for (int i = 0; i < FRAME; i++) pe ^= bits[i];
`endif
            bits.delete();
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (done && m_v[k] && !dout_ready) begin
            m_o[k] = 1;
         end else begin
            if (done) begin
               m_dout[k] = w[k]; m_v[k] = 1; m_p[k] = pe;
            end else if (m_v[k] && dout_ready) begin
               m_v[k] = 0;
            end
            if (clr_ovr) m_o[k] = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("msb_vld",  v_m,    m_v[0]);
      check("msb_dout", dout_m, m_dout[0]);
      check("msb_ovr",  o_m,    m_o[0]);
      check("msb_perr", p_m,    m_p[0]);
      check("lsb_vld",  v_l,    m_v[1]);
      check("lsb_dout", dout_l, m_dout[1]);
      check("lsb_ovr",  o_l,    m_o[1]);
      check("lsb_perr", p_l,    m_p[1]);
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input bit s, input bit v, input bit y, input bit r, input bit c);
      sin = s; sin_valid = v; sync = y; dout_ready = r; clr_ovr = c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   // b[W-1] goes out first; a correct even-parity bit follows in parity builds.
   task automatic send_word(input logic [W-1:0] b, input bit r_other, input bit r_last, input bit c_last);
      for (int i = 0; i < W; i++) begin
         if (i == W - 1 && FRAME == W) step(b[W-1-i], 1, 0, r_last, c_last);
         else                          step(b[W-1-i], 1, 0, r_other, 0);
      end
`ifdef PARITY_EN
      step(^b, 1, 0, r_last, c_last);
`endif
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) step(0, 0, 0, r, 0);
   endtask

   initial begin
      logic [W-1:0] pat;
      reset = 0; sin = 0; sin_valid = 0; sync = 0; dout_ready = 0; clr_ovr = 0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      check("rst_dout", dout_m, 0);
      reset = 1;

      // 1,1,0,1 back to back: D from MSB-first, B from LSB-first, valid one cycle
      send_word(4'b1101, 1, 1, 0);
      check("b2b_msb_D", dout_m, 4'hD);
      check("b2b_lsb_B", dout_l, 4'hB);
      check("b2b_vld", v_m, 1);
      idle(1, 1);
      check("b2b_vld_drop", v_m, 0);

      // same bits with 3-cycle gaps
      pat = 4'b1101;
      for (int i = 0; i < W; i++) begin
         step(pat[W-1-i], 1, 0, 1, 0);
         idle(3, 1);
      end
`ifdef PARITY_EN
      step(^pat, 1, 0, 1, 0);
`endif
      idle(3, 1);
      check("gap_msb_D", dout_m, 4'hD);
      check("gap_lsb_B", dout_l, 4'hB);

      // partial word discarded by sync
      step(1, 1, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      step(0, 1, 1, 1, 0);
      pat = 4'b0110;
      for (int i = 1; i < FRAME; i++) step((i < W) ? pat[W-1-i] : ^pat, 1, 0, 1, 0);
      check("sync_msb_6", dout_m, 4'h6);
      check("sync_lsb_6", dout_l, 4'h6);
      check("sync_no_ovr", o_m, 0);
      idle(2, 1);

      // overrun: D held, 3 dropped; clear; set wins over clear
      send_word(4'hD, 0, 0, 0);
      send_word(4'h3, 0, 0, 0);
      check("ovr_hold_D", dout_m, 4'hD);
      check("ovr_set", o_m, 1);
      step(0, 0, 0, 0, 1);
      check("ovr_clr", o_m, 0);
      send_word(4'h3, 0, 0, 1);
      check("ovr_set_wins", o_m, 1);
      check("ovr_hold_D2", dout_m, 4'hD);
      step(0, 0, 0, 1, 1);
      idle(1, 1);

      // accept edge coincides with next completion
      send_word(4'hA, 1, 1, 0);
      check("acc_A", dout_m, 4'hA);
      send_word(4'h5, 0, 1, 0);
      check("acc_5", dout_m, 4'h5);
      check("acc_vld", v_m, 1);
      check("acc_no_ovr", o_m, 0);
      idle(2, 1);

`ifdef PARITY_EN
      pat = 4'b1101;
      for (int i = 0; i < W; i++) step(pat[W-1-i], 1, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      check("par_ok", p_m, 0);
      for (int i = 0; i < W; i++) step(pat[W-1-i], 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      check("par_err", p_m, 1);
      check("par_err_dout", dout_m, 4'hD);
      idle(1, 1);
`endif

      // reset mid-frame, then a clean frame
      send_word(4'hE, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      reset = 0;
      #1;
      model_reset();
      check("mid_rst_dout", dout_m, 0);
      check("mid_rst_vld", v_m, 0);
      compare_all();
      @(negedge clk);
      reset = 1;
      send_word(4'h9, 1, 1, 0);
      check("post_rst_9", dout_m, 4'h9);
      check("post_rst_lsb", dout_l, 4'h9);
      idle(1, 1);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 1), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
              $urandom_range(0, 1), $urandom_range(0, 9) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
